// File: rtl/button_event_decoder.sv
// Classifies debounced button gestures into one-cycle event pulses (press, release,
// short/double click, long press, auto-repeat). Define AUTOREPEAT_EN to enable repeat.
module button_event_decoder #(
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned LONG_TICKS   = 50,
  parameter int unsigned DBL_TICKS    = 25,
  parameter int unsigned REPEAT_TICKS = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic debounced,
  input  logic tick,
  output logic press,
  output logic release_pulse,
  output logic short_click,
  output logic double_click,
  output logic long_press,
  output logic repeat_pulse,
  output logic busy
);

`ifdef AUTOREPEAT_EN
  localparam logic AUTOREPEAT = 1'b1;
`else
  localparam logic AUTOREPEAT = 1'b0;
`endif

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DBL_TICKS - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_TICKS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    WAIT2  = 3'd2,
    PRESS2 = 3'd3,
    LONG   = 3'd4
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             d_q;
  logic             rise;
  logic             fall;

  assign rise = debounced & ~d_q;
  assign fall = ~debounced & d_q;

  // Gesture FSM; edges take priority over timer expiry in every state.
  always_ff @(posedge clk) begin
    if (reset) begin
      d_q           <= debounced;
      state         <= IDLE;
      cnt           <= '0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      short_click   <= 1'b0;
      double_click  <= 1'b0;
      long_press    <= 1'b0;
      repeat_pulse  <= 1'b0;
      busy          <= 1'b0;
    end else begin
      d_q           <= debounced;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      short_click   <= 1'b0;
      double_click  <= 1'b0;
      long_press    <= 1'b0;
      repeat_pulse  <= 1'b0;
      if (tick && (cnt != '1)) cnt <= cnt + CNT_W'(1);

      case (state)
        IDLE: begin
          if (rise) begin
            state <= PRESS1;
            cnt   <= '0;
            press <= 1'b1;
            busy  <= 1'b1;
          end
        end
        PRESS1: begin
          if (fall) begin
            state         <= WAIT2;
            cnt           <= '0;
            release_pulse <= 1'b1;
          end else if (tick && (cnt == LONG_LAST)) begin
            state      <= LONG;
            cnt        <= '0;
            long_press <= 1'b1;
          end
        end
        WAIT2: begin
          if (rise) begin
            state        <= PRESS2;
            cnt          <= '0;
            press        <= 1'b1;
            double_click <= 1'b1;
          end else if (tick && (cnt == DBL_LAST)) begin
            state       <= IDLE;
            cnt         <= '0;
            short_click <= 1'b1;
            busy        <= 1'b0;
          end
        end
        PRESS2: begin
          if (fall) begin
            state         <= IDLE;
            cnt           <= '0;
            release_pulse <= 1'b1;
            busy          <= 1'b0;
          end
        end
        LONG: begin
          if (fall) begin
            state         <= IDLE;
            cnt           <= '0;
            release_pulse <= 1'b1;
            busy          <= 1'b0;
          end else if (AUTOREPEAT && tick && (cnt == REP_LAST)) begin
            cnt          <= '0;
            repeat_pulse <= 1'b1;
          end else if (!AUTOREPEAT) begin
            cnt <= cnt;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
